seq_div_radix2: RTL and testbench
=================================

Name: seq_div_radix2

Overview:
- Iterative radix-2 non-restoring divider: the inverse of the team's partial-product multiplier tree.
- Shares the multiplier's operand width and op1/op2 naming.
- Sits beside the multiplier in the execute datapath.
- Takes one dividend/divisor pair per transaction through a valid/ready handshake and returns quotient and remainder after DATA_LEN iteration cycles.
- Signed or unsigned operation is selected by parameter.

Parameters:
- DATA_LEN, 8, operand/result width in bits; must be >= 2.
- SIGNED, 0, 0 = unsigned divide; 1 = two's-complement divide with truncation toward zero.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous abort of any in-flight operation.
- in_valid  input  1  op1/op2 valid.
- in_ready  output  1  divider can accept operands.
- op1  input  DATA_LEN  dividend.
- op2  input  DATA_LEN  divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  DATA_LEN  quotient.
- remainder  output  DATA_LEN  remainder.
- div_by_zero  output  1  set with the result when op2 == 0.

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (rst=1): state=IDLE, iteration count=0, out_valid=0, quotient=0, remainder=0, div_by_zero=0, in_ready=1 from the next cycle.
- in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept: in_valid & in_ready at edge T latches the operands.
  - SIGNED=1: absolute values are latched, plus the sign of op1 and the XOR of the operand signs.
- Special cases are checked at accept and skip CALC: state goes straight to DONE, so out_valid=1 at T+1.
  - op2==0: quotient = all ones, remainder = op1 (raw), div_by_zero=1.
  - SIGNED=1 and op1 == most-negative and op2 == all ones: quotient = op1, remainder = 0, div_by_zero=0.
- Normal case: state=CALC, count=0.
  - Each CALC cycle performs one non-restoring step. Partial remainder is DATA_LEN+1 bits; add or subtract the divisor based on the partial-remainder sign; shift in one quotient bit.
  - count increments each cycle. When count==DATA_LEN-1, the final step is taken along with the remainder restore (add divisor if the partial remainder is negative) and the sign fix-up, and the result is registered.
  - Sign fix-up: negate the quotient if the signs differ; give the remainder the dividend's sign.
  - After that edge, state=DONE. out_valid first high at T+DATA_LEN+1.
- DONE: quotient/remainder/div_by_zero are held stable while out_valid & !out_ready.
  - out_valid & out_ready moves to IDLE on that edge. in_ready=1 next cycle.
  - No same-cycle accept of new operands. Throughput: one op per DATA_LEN+2 cycles minimum.
- in_valid while busy: ignored, no latching. op1/op2 changes during CALC have no effect.
- flush=1: next state IDLE, out_valid=0, partial state discarded, result registers unchanged. Precedence: rst > flush > handshake.
- rst or flush mid-CALC or in DONE: returns to IDLE the next cycle, and no stale out_valid is ever produced.
- Unsigned remainder is always < divisor. Signed results satisfy op1 == q*op2 + r, with |r| < |op2|.

Decomposition:
- Shared package mul_div_pkg:
  - DATA_LEN localparam, shared with mul_4to2_tree.
  - div_state_t enum {IDLE, CALC, DONE}.
  - Helper function for two's-complement negate.
- One natural sub-module: div_nr_step. Combinational single non-restoring iteration: partial remainder, dividend bit, divisor in; next partial remainder and quotient bit out.
- The FSM, counter and sign handling stay in seq_div_radix2.

Test Plan (DATA_LEN=8):
- SIGNED=0, op1=200, op2=7, accepted at T -> out_valid at T+9; quotient=28, remainder=4, div_by_zero=0.
- SIGNED=0, op1=55, op2=0 -> out_valid at T+1; quotient=0xFF, remainder=55, div_by_zero=1.
- SIGNED=1, op1=0xF9 (-7), op2=0x02 -> quotient=0xFD (-3), remainder=0xFF (-1); and op1=0x07, op2=0xFE -> quotient=0xFD, remainder=0x01.
- SIGNED=1, op1=0x80, op2=0xFF -> out_valid at T+1; quotient=0x80, remainder=0x00, div_by_zero=0.
- Backpressure: out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands driven -> outputs stable, in_ready=0, no accept. Then out_ready=1 -> IDLE, and the new operands are accepted the next cycle.
- rst (and separately flush) asserted on the 4th CALC cycle -> next cycle state IDLE, out_valid=0, in_ready=1. A following 255/255 gives quotient=1, remainder=0.

Source files
------------

// File: rtl/mul_div_pkg.sv
// -----------------------------------------------------------------------------
// mul_div_pkg
// Definitions shared by the execute-stage multiply and divide units:
//   DATA_LEN     - default operand/result width, also used by mul_4to2_tree
//   div_state_t  - control states of the iterative divider
//   twos_neg     - two's-complement negate. It works on a wide vector so one
//                  function serves every operand width; callers truncate the
//                  result to their own width.
// -----------------------------------------------------------------------------
package mul_div_pkg;

  localparam int DATA_LEN  = 8;
  localparam int NEG_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // The low bits of a wide negate equal the negate at any narrower width.
  function automatic logic [NEG_MAX_W-1:0] twos_neg(input logic [NEG_MAX_W-1:0] a);
    return ~a + NEG_MAX_W'(1);
  endfunction

endpackage

// File: rtl/seq_div_radix2_if.sv
// -----------------------------------------------------------------------------
// seq_div_radix2_if
// Operand/result handshake bundle of the radix-2 divider.
//   flush        - abort any in-flight operation (driven by the requester)
//   in_valid     - op1/op2 valid                  in_ready  - divider idle
//   op1, op2     - dividend, divisor
//   out_valid    - result valid                   out_ready - consumer accepts
//   quotient, remainder, div_by_zero - result
// modport master: requester/consumer side.  modport slave: the divider.
// -----------------------------------------------------------------------------
interface seq_div_radix2_if #(
  parameter int DATA_LEN = mul_div_pkg::DATA_LEN
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_LEN-1:0] op1;
  logic [DATA_LEN-1:0] op2;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] quotient;
  logic [DATA_LEN-1:0] remainder;
  logic                div_by_zero;

  modport master (
    output flush, in_valid, op1, op2, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  flush, in_valid, op1, op2, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_div_radix2_step.sv
// -----------------------------------------------------------------------------
// div_nr_step
// One combinational non-restoring division iteration.
//   prem_i    - current partial remainder (DATA_LEN+1 bits, two's complement)
//   dvd_bit_i - next dividend bit shifted into the partial remainder
//   dvs_i     - divisor magnitude
//   prem_o    - next partial remainder
//   q_bit_o   - quotient bit (1 when the new partial remainder is >= 0)
// -----------------------------------------------------------------------------
module div_nr_step #(
  parameter int DATA_LEN = mul_div_pkg::DATA_LEN
) (
  input  logic signed [DATA_LEN:0]   prem_i,
  input  logic                       dvd_bit_i,
  input  logic        [DATA_LEN-1:0] dvs_i,
  output logic signed [DATA_LEN:0]   prem_o,
  output logic                       q_bit_o
);

  logic signed [DATA_LEN:0] shifted;
  logic signed [DATA_LEN:0] dvs_ext;

  // 2*prem+bit may leave the DATA_LEN+1 range, but the sum after adding or
  // subtracting the divisor always lies in [-dvs, dvs), so modular wrap of
  // the intermediate value is harmless.
  assign shifted = {prem_i[DATA_LEN-1:0], dvd_bit_i};
  assign dvs_ext = {1'b0, dvs_i};
  assign prem_o  = prem_i[DATA_LEN] ? (shifted + dvs_ext) : (shifted - dvs_ext);
  assign q_bit_o = ~prem_o[DATA_LEN];

endmodule

// File: rtl/seq_div_radix2.sv
// -----------------------------------------------------------------------------
// seq_div_radix2
// Iterative radix-2 non-restoring divider, one quotient bit per cycle.
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset
//   dif  - slave side of seq_div_radix2_if (flush, operand and result
//          handshakes, quotient/remainder/div_by_zero)
// Parameters: DATA_LEN operand width (>= 2); SIGNED 0 = unsigned,
// 1 = two's-complement with truncation toward zero.
// Divide-by-zero and the signed most-negative / -1 overflow complete in one
// cycle; every other operation takes DATA_LEN CALC cycles.
// -----------------------------------------------------------------------------
module seq_div_radix2 #(
  parameter int DATA_LEN = mul_div_pkg::DATA_LEN,
  parameter bit SIGNED   = 1'b0
) (
  input logic             clk,
  input logic             rst,
  seq_div_radix2_if.slave dif
);
  import mul_div_pkg::*;

  localparam int W     = DATA_LEN;
  localparam int CNT_W = $clog2(DATA_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_LEN - 1);
  localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] a);
    return W'(twos_neg(NEG_MAX_W'(a)));
  endfunction

  div_state_t          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic signed [W:0]   prem_q;
  logic [W-1:0]        dvd_q;    // dividend bits shift out, quotient bits shift in
  logic [W-1:0]        dvs_q;
  logic                qneg_q;
  logic                rneg_q;
  logic [W-1:0]        quo_q;
  logic [W-1:0]        rem_q;
  logic                dbz_q;

  logic                op1_neg, op2_neg;
  logic [W-1:0]        op1_abs, op2_abs;
  logic                is_ovf;
  logic signed [W:0]   step_prem;
  logic                step_q;
  logic [W-1:0]        quo_raw, rem_raw;
  logic [W-1:0]        quo_fin, rem_fin;

  // Operand conditioning at accept
  assign op1_neg = SIGNED & dif.op1[W-1];
  assign op2_neg = SIGNED & dif.op2[W-1];
  assign op1_abs = op1_neg ? neg_w(dif.op1) : dif.op1;
  assign op2_abs = op2_neg ? neg_w(dif.op2) : dif.op2;
  assign is_ovf  = SIGNED & (dif.op1 == MOST_NEG) & (dif.op2 == '1);

  div_nr_step #(.DATA_LEN(W)) u_step (
    .prem_i    (prem_q),
    .dvd_bit_i (dvd_q[W-1]),
    .dvs_i     (dvs_q),
    .prem_o    (step_prem),
    .q_bit_o   (step_q)
  );

  // Final-step result: restore a negative remainder, then apply signs
  assign quo_raw = {dvd_q[W-2:0], step_q};
  assign rem_raw = step_prem[W] ? (step_prem[W-1:0] + dvs_q) : step_prem[W-1:0];
  assign quo_fin = qneg_q ? neg_w(quo_raw) : quo_raw;
  assign rem_fin = rneg_q ? neg_w(rem_raw) : rem_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else if (dif.flush) begin
      // Result registers keep their last value; only control is discarded.
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dif.in_valid) begin
            dvd_q  <= op1_abs;
            dvs_q  <= op2_abs;
            prem_q <= '0;
            qneg_q <= op1_neg ^ op2_neg;
            rneg_q <= op1_neg;
            cnt_q  <= '0;
            if (dif.op2 == '0) begin
              quo_q   <= '1;
              rem_q   <= dif.op1;
              dbz_q   <= 1'b1;
              state_q <= DONE;
            end else if (is_ovf) begin
              quo_q   <= dif.op1;
              rem_q   <= '0;
              dbz_q   <= 1'b0;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          prem_q <= step_prem;
          dvd_q  <= quo_raw;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            quo_q   <= quo_fin;
            rem_q   <= rem_fin;
            dbz_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (dif.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dif.in_ready    = (state_q == IDLE);
  assign dif.out_valid   = (state_q == DONE);
  assign dif.quotient    = quo_q;
  assign dif.remainder   = rem_q;
  assign dif.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_radix2.sv
// -----------------------------------------------------------------------------
// tb_seq_div_radix2
// Bench for seq_div_radix2 with DATA_LEN=8: one unsigned and one signed
// instance, directed cases followed by random operands against an
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_seq_div_radix2;
  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_u, rst_s;

  seq_div_radix2_if #(.DATA_LEN(N)) if_u ();
  seq_div_radix2_if #(.DATA_LEN(N)) if_s ();

  seq_div_radix2 #(.DATA_LEN(N), .SIGNED(1'b0)) dut_u (.clk(clk), .rst(rst_u), .dif(if_u.slave));
  seq_div_radix2 #(.DATA_LEN(N), .SIGNED(1'b1)) dut_s (.clk(clk), .rst(rst_s), .dif(if_s.slave));

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero when signed.
  function automatic void ref_div(input bit sgn, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r, output logic z);
    int sa, sb;
    z = 1'b0;
    if (b == 8'd0) begin
      q = 8'hFF; r = a; z = 1'b1;
    end else if (!sgn) begin
      q = a / b; r = a % b;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      if (sa == -128 && sb == -1) begin
        q = a; r = 8'd0;
      end else begin
        q = 8'(sa / sb); r = 8'(sa % sb);
      end
    end
  endfunction

  function automatic int ref_lat(input bit sgn, input logic [7:0] a, input logic [7:0] b);
    if (b == 8'd0 || (sgn && a == 8'h80 && b == 8'hFF)) return 1;
    return N + 1;
  endfunction

  task automatic drive(input bit s, input logic v, input logic [7:0] a, input logic [7:0] b);
    if (s) begin if_s.in_valid = v; if_s.op1 = a; if_s.op2 = b; end
    else   begin if_u.in_valid = v; if_u.op1 = a; if_u.op2 = b; end
  endtask

  function automatic logic       g_ov(input bit s); return s ? if_s.out_valid   : if_u.out_valid;   endfunction
  function automatic logic       g_ir(input bit s); return s ? if_s.in_ready    : if_u.in_ready;    endfunction
  function automatic logic [7:0] g_q (input bit s); return s ? if_s.quotient    : if_u.quotient;    endfunction
  function automatic logic [7:0] g_r (input bit s); return s ? if_s.remainder   : if_u.remainder;   endfunction
  function automatic logic       g_z (input bit s); return s ? if_s.div_by_zero : if_u.div_by_zero; endfunction

  // Waits (bounded) for out_valid; k counts cycles from the accept edge so
  // that out_valid in the cycle right after accept gives k=1 (T+1).
  task automatic wait_result(input bit s, output int k);
    k = 1;
    while (!g_ov(s) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  // One full transaction with out_ready held high. Called at posedge+1.
  task automatic run_op(input bit s, input logic [7:0] a, input logic [7:0] b, input string tag,
                        output logic [7:0] q, output logic [7:0] r);
    logic [7:0] eq, er;
    logic       ez;
    int         k;
    ref_div(s, a, b, eq, er, ez);
    chk({tag, ".in_ready"}, g_ir(s), 1);
    drive(s, 1'b1, a, b);
    @(posedge clk); #1;
    drive(s, 1'b0, 8'($urandom), 8'($urandom));
    wait_result(s, k);
    chk({tag, ".latency"}, k, ref_lat(s, a, b));
    q = g_q(s);
    r = g_r(s);
    chk({tag, ".quotient"},  q,      eq);
    chk({tag, ".remainder"}, r,      er);
    chk({tag, ".dbz"},       g_z(s), ez);
    @(posedge clk); #1;
    chk({tag, ".back_idle"}, {g_ir(s), g_ov(s)}, 2'b10);
  endtask

  // rst or flush during the 4th CALC cycle, then 255/255.
  task automatic abort_test(input bit s, input bit use_flush, input string tag);
    logic [7:0] prev_q, q, r;
    logic       any_ov;
    prev_q = g_q(s);
    drive(s, 1'b1, 8'd200, 8'd3);
    @(posedge clk); #1;
    drive(s, 1'b0, 8'd0, 8'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk({tag, ".calc_busy"}, {g_ir(s), g_ov(s)}, 2'b00);
    if (use_flush) begin if (s) if_s.flush = 1'b1; else if_u.flush = 1'b1; end
    else           begin if (s) rst_s = 1'b1;      else rst_u = 1'b1;      end
    @(posedge clk); #1;
    if_s.flush = 1'b0; if_u.flush = 1'b0; rst_s = 1'b0; rst_u = 1'b0;
    chk({tag, ".idle"}, {g_ir(s), g_ov(s)}, 2'b10);
    chk({tag, ".quotient_kept"}, g_q(s), use_flush ? prev_q : 8'd0);
    any_ov = 1'b0;
    repeat (12) begin @(posedge clk); #1; any_ov |= g_ov(s); end
    chk({tag, ".no_stale_valid"}, any_ov, 1'b0);
    run_op(s, 8'd255, 8'd255, {tag, ".ff_ff"}, q, r);
    chk({tag, ".ff_ff.q1"}, q, 8'd1);
    chk({tag, ".ff_ff.r0"}, r, 8'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q, r, q0, r0, a, b, eq, er;
    logic       ez;
    int         k;

    rst_u = 1'b1; rst_s = 1'b1;
    if_u.flush = 1'b0; if_s.flush = 1'b0;
    if_u.out_ready = 1'b1; if_s.out_ready = 1'b1;
    drive(0, 1'b0, 8'd0, 8'd0);
    drive(1, 1'b0, 8'd0, 8'd0);
    repeat (2) begin @(posedge clk); #1; end

    // Reset state
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset%0d.ctrl", s), {g_ir(s[0]), g_ov(s[0])}, 2'b10);
      chk($sformatf("reset%0d.res", s),  {g_q(s[0]), g_r(s[0]), g_z(s[0])}, 17'd0);
    end
    rst_u = 1'b0; rst_s = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op(0, 8'd200, 8'd7, "u200_7", q, r);
    chk("u200_7.q28", q, 8'd28);
    chk("u200_7.r4",  r, 8'd4);
    run_op(0, 8'd55, 8'd0, "u55_0", q, r);
    chk("u55_0.qff", q, 8'hFF);
    run_op(1, 8'hF9, 8'h02, "sm7_2", q, r);
    chk("sm7_2.qfd", q, 8'hFD);
    chk("sm7_2.rff", r, 8'hFF);
    run_op(1, 8'h07, 8'hFE, "s7_m2", q, r);
    chk("s7_m2.r01", r, 8'h01);
    run_op(1, 8'h80, 8'hFF, "sovf", q, r);
    chk("sovf.q80", q, 8'h80);

    // Backpressure in DONE with new operands pending
    if_u.out_ready = 1'b0;
    drive(0, 1'b1, 8'd100, 8'd9);
    @(posedge clk); #1;
    drive(0, 1'b1, 8'd77, 8'd5);
    wait_result(0, k);
    chk("bp.latency", k, N + 1);
    q0 = g_q(0); r0 = g_r(0);
    chk("bp.result", {q0, r0}, {8'd11, 8'd1});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp.hold%0d", i), {g_ov(0), g_ir(0), g_q(0), g_r(0), g_z(0)},
          {1'b1, 1'b0, q0, r0, 1'b0});
    end
    if_u.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release_idle", {g_ir(0), g_ov(0)}, 2'b10);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'd0, 8'd0);
    chk("bp.new_accepted", g_ir(0), 1'b0);
    wait_result(0, k);
    ref_div(0, 8'd77, 8'd5, eq, er, ez);
    chk("bp.new_latency", k, N + 1);
    chk("bp.new_result", {g_q(0), g_r(0), g_z(0)}, {eq, er, ez});
    @(posedge clk); #1;

    // Flush while holding a result in DONE: valid drops, result retained
    if_s.out_ready = 1'b0;
    drive(1, 1'b1, 8'd9, 8'd0);
    @(posedge clk); #1;
    drive(1, 1'b0, 8'd0, 8'd0);
    chk("dflush.valid", g_ov(1), 1'b1);
    if_s.flush = 1'b1;
    @(posedge clk); #1;
    if_s.flush = 1'b0;
    if_s.out_ready = 1'b1;
    chk("dflush.idle", {g_ir(1), g_ov(1)}, 2'b10);
    chk("dflush.kept", {g_q(1), g_r(1), g_z(1)}, {8'hFF, 8'd9, 1'b1});

    // Abort mid-CALC
    abort_test(0, 1'b0, "u_rst");
    abort_test(0, 1'b1, "u_flush");
    abort_test(1, 1'b0, "s_rst");
    abort_test(1, 1'b1, "s_flush");

    // Random operands against the reference model
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 40; i++) begin
        a = 8'($urandom);
        b = 8'($urandom);
        if (i % 9 == 4) b = 8'd0;
        if (s == 1 && i % 13 == 6) begin a = 8'h80; b = 8'hFF; end
        if (i % 11 == 3) b = 8'd1;
        run_op(s[0], a, b, $sformatf("rnd%0d_%0d", s, i), q, r);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
